data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store path and data_mem.
//  One 32-bit word per line; read hits return data combinationally with no stall.
//  Read misses refill from memory; all stores write through.
//  The CPU is held via cpu_stall while the memory-side handshake completes.
// PARAMETERS
//  DATA_WIDTH  32   data/word width in bits (fixed at 32; byte enables assume 4 bytes)
//  ADDR_WIDTH  32   byte address width
//  SETS        256  number of lines; power of 2, >= 2; IDX = log2(SETS)
// PORTS
//  clk        in   1           rising-edge clock, single clock domain
//  rst        in   1           asynchronous, active-high reset
//  cpu_req    in   1           CPU access valid this cycle; held with addr/data while cpu_stall=1
//  cpu_we     in   1           1 = store, 0 = load
//  cpu_be     in   4           store byte enables, bit i -> bits [8i+7:8i]; ignored on loads
//  cpu_addr   in   ADDR_WIDTH  byte address; [1:0] ignored (word access)
//  cpu_wdata  in   DATA_WIDTH  store data, byte lanes already aligned
//  cpu_rdata  out  DATA_WIDTH  load data; valid when cpu_req & !cpu_we & !cpu_stall
//  cpu_stall  out  1           CPU must hold its request and not advance
//  mem_req    out  1           memory access pending; held high until mem_ready
//  mem_we     out  1           1 = write-through store, 0 = refill read
//  mem_be     out  4           byte enables for mem writes (4'hF on reads)
//  mem_addr   out  ADDR_WIDTH  word-aligned byte address {addr[31:2],2'b00}
//  mem_wdata  out  DATA_WIDTH  write-through data
//  mem_rdata  in   DATA_WIDTH  refill data, sampled when mem_ready=1 in FILL
//  mem_ready  in   1           access complete this cycle (>=1 cycle after mem_req rises)
// BEHAVIOUR
//  Address split: index = addr[IDX+1:2], tag = addr[ADDR_WIDTH-1:IDX+2]; hit = valid[index] & tag match.
//  Storage: per line valid bit, tag, and 32-bit data; reset clears every valid bit asynchronously.
//  Tags and data are not reset.
//  FSM states: IDLE, FILL, WRITE, DONE. Reset -> IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
//  In IDLE:
//   - No cpu_req: cpu_stall=0.
//   - Load hit: cpu_rdata = line data (combinational), cpu_stall=0, stay IDLE.
//   - Load miss: cpu_stall=1. At the next edge, latch the word address and go to FILL with mem_req=1, mem_we=0, mem_be=4'hF.
//   - Store (hit or miss): cpu_stall=1. At the next edge, latch address/be/wdata and the hit result,
//     then go to WRITE with mem_req=1, mem_we=1.
//  FILL: cpu_stall=1; mem outputs held stable. On an edge with mem_ready=1:
//   - write mem_rdata into the line, set valid, write the tag (replacing any old line);
//   - mem_req->0; go to IDLE.
//   - The CPU, still holding the load, then hits with cpu_stall=0.
//  WRITE: cpu_stall=1; mem outputs held stable. On an edge with mem_ready=1:
//   - if the latched hit=1, merge the enabled bytes into the line (valid/tag unchanged);
//   - a miss leaves the cache untouched (no allocate);
//   - mem_req->0; go to DONE.
//  DONE: cpu_stall=0 for exactly one cycle so the CPU retires the store.
//   cpu_req is ignored this cycle; next state is IDLE unconditionally.
//  Latency:
//   - load hit 0 stall cycles;
//   - load miss = N+1 stall cycles, where N = cycles mem_req is high up to and including the mem_ready cycle;
//   - store = N+1 stall cycles, then 1 DONE cycle.
//  mem_ready outside FILL/WRITE is ignored. mem_req never re-asserts in the same cycle it completes.
//  cpu_rdata when not a valid hit: don't-care, but must not be X-propagating from uninitialised lines after reset (drive line data).
//  Reset mid-FILL/WRITE: mem_req drops immediately, FSM -> IDLE, all lines invalid; the partial access is abandoned.
//  Back-to-back same-line accesses: a store hit followed by a load to the same address returns the merged data with no stall.
// TESTING
//  1. Reset, load 0x00010000, mem_ready 3 cycles after mem_req with 0xDEADBEEF ->
//     mem_addr=0x00010000, mem_we=0, cpu_stall high 4 cycles, then cpu_rdata=0xDEADBEEF, stall 0.
//  2. Repeat the load of 0x00010000 -> no mem_req, cpu_rdata=0xDEADBEEF same cycle, stall 0.
//  3. Store be=4'b0010 wdata=0x0000AB00 to 0x00010000, mem_ready after 1 cycle ->
//     mem_we=1, mem_be=2, one DONE cycle; next load returns 0xDEADABEF without mem_req.
//  4. Load 0x00010400 (same index, SETS=256, different tag), refill 0x12345678 -> line replaced;
//     a following load of 0x00010000 misses again (mem_req=1).
//  5. Store to uncached 0x00000100 -> write-through seen on mem side;
//     a following load of 0x00000100 still misses (no allocate).
//  6. Assert rst during FILL before mem_ready -> mem_req=0 same cycle, cpu_stall=0 with cpu_req low;
//     a prior-hit address now misses.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// One 32-bit word per line. Load hits are served combinationally; load misses
// refill the line from memory; every store is written through to memory.
module data_cache #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SETS       = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [3:0]            cpu_be,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX - 2;

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

    state_e                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [3:0]              mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    hit_q, hit_d;
    logic [SETS-1:0]         valid_q, valid_d;

    // Line storage; tags and data are deliberately not reset.
    logic [DATA_WIDTH-1:0]   data_q [SETS];
    logic [TAG_W-1:0]        tag_q  [SETS];

    logic [IDX-1:0]          cpu_idx, lat_idx;
    logic [TAG_W-1:0]        cpu_tag, lat_tag;
    logic                    hit;
    logic                    line_we, tag_we;
    logic [DATA_WIDTH-1:0]   line_wdata;
    logic [DATA_WIDTH-1:0]   merged;

    assign cpu_idx = cpu_addr[IDX+1:2];
    assign cpu_tag = cpu_addr[ADDR_WIDTH-1:IDX+2];
    // The latched memory address doubles as the line address for refills/merges.
    assign lat_idx = mem_addr_q[IDX+1:2];
    assign lat_tag = mem_addr_q[ADDR_WIDTH-1:IDX+2];
    assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // Line data always drives the read port, so the don't-care case stays X-free.
    assign cpu_rdata = data_q[cpu_idx];

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Merge the latched store bytes into the current line contents.
    always_comb begin
        merged = data_q[lat_idx];
        for (int i = 0; i < 4; i++) begin
            if (mem_be_q[i]) begin
                merged[8*i +: 8] = mem_wdata_q[8*i +: 8];
            end
        end
    end

    // Next-state, memory-side request and line update decisions.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_d       = hit_q;
        valid_d     = valid_q;
        cpu_stall   = 1'b0;
        line_we     = 1'b0;
        tag_we      = 1'b0;
        line_wdata  = mem_rdata;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (!cpu_we && hit) begin
                        cpu_stall = 1'b0;
                    end else begin
                        cpu_stall  = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = cpu_addr & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
                        if (cpu_we) begin
                            mem_we_d    = 1'b1;
                            mem_be_d    = cpu_be;
                            mem_wdata_d = cpu_wdata;
                            hit_d       = hit;
                            state_d     = StWrite;
                        end else begin
                            mem_we_d = 1'b0;
                            mem_be_d = 4'hF;
                            state_d  = StFill;
                        end
                    end
                end
            end
            StFill: begin
                cpu_stall = 1'b1;
                if (mem_ready) begin
                    line_we          = 1'b1;
                    tag_we           = 1'b1;
                    line_wdata       = mem_rdata;
                    valid_d[lat_idx] = 1'b1;
                    mem_req_d        = 1'b0;
                    state_d          = StIdle;
                end
            end
            StWrite: begin
                cpu_stall = 1'b1;
                if (mem_ready) begin
                    // No allocate: a store miss leaves the cache untouched.
                    line_we    = hit_q;
                    line_wdata = merged;
                    mem_req_d  = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                // One unstalled cycle lets the CPU retire the store; cpu_req is ignored.
                cpu_stall = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state, memory request registers and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_q       <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_q       <= hit_d;
            valid_q     <= valid_d;
        end
    end

    // Line data and tag arrays, written on refill or store-hit merge.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[lat_idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[lat_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a table of CPU accesses with hand-computed
// memory-side and CPU-side results, plus hand-written reset sequences.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_cache #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .SETS(256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_be   (cpu_be),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;        // mem_ready on this mem_req-high cycle
        logic [31:0] mrdata;     // refill data returned by memory
        logic        exp_mem;    // a memory access is expected
        logic [3:0]  exp_mbe;
        logic [31:0] exp_maddr;
        logic [31:0] exp_rdata;  // checked for loads only
        int          exp_stalls;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one access, act as the memory, and check the outcome.
    task automatic access(input vec_t v);
        int  stalls = 0;
        int  memcyc = 0;
        bit  done   = 0;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_be    = v.be;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        mem_ready = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (!cpu_stall) begin
                done      = 1;
                mem_ready = 1'b0;
            end else begin
                stalls++;
                if (mem_req) begin
                    memcyc++;
                    if (memcyc == 1) begin
                        check({v.name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
                        check({v.name, " mem_be"}, {28'd0, mem_be}, {28'd0, v.exp_mbe});
                        check({v.name, " mem_addr"}, mem_addr, v.exp_maddr);
                        if (v.we) check({v.name, " mem_wdata"}, mem_wdata, v.wdata);
                    end
                    mem_ready = (memcyc == v.lat);
                    mem_rdata = v.mrdata;
                end else begin
                    mem_ready = 1'b0;
                end
                @(negedge clk);
            end
        end
        check({v.name, " finished"}, {31'd0, done}, 32'd1);
        check({v.name, " stalls"}, stalls, v.exp_stalls);
        check({v.name, " mem access"}, {31'd0, memcyc > 0}, {31'd0, v.exp_mem});
        check({v.name, " mem_req low"}, {31'd0, mem_req}, 32'd0);
        if (!v.we) check({v.name, " rdata"}, cpu_rdata, v.exp_rdata);
    endtask

    vec_t vecs[11];
    vec_t v;
    bit   seen;

    initial begin
        //        name        we  be     addr          wdata         lat mrdata        mem  mbe   maddr         rdata         stalls
        vecs[0]  = '{"ld_miss",  0, 4'h0, 32'h00010000, 32'h0,        3, 32'hDEADBEEF, 1, 4'hF, 32'h00010000, 32'hDEADBEEF, 4};
        vecs[1]  = '{"ld_hit",   0, 4'h0, 32'h00010000, 32'h0,        1, 32'h0,        0, 4'hF, 32'h0,        32'hDEADBEEF, 0};
        vecs[2]  = '{"st_hit",   1, 4'h2, 32'h00010000, 32'h0000AB00, 1, 32'h0,        1, 4'h2, 32'h00010000, 32'h0,        2};
        vecs[3]  = '{"ld_merge", 0, 4'h0, 32'h00010000, 32'h0,        1, 32'h0,        0, 4'hF, 32'h0,        32'hDEADABEF, 0};
        vecs[4]  = '{"ld_evict", 0, 4'h0, 32'h00010400, 32'h0,        2, 32'h12345678, 1, 4'hF, 32'h00010400, 32'h12345678, 3};
        vecs[5]  = '{"ld_remiss",0, 4'h0, 32'h00010000, 32'h0,        1, 32'hDEADABEF, 1, 4'hF, 32'h00010000, 32'hDEADABEF, 2};
        vecs[6]  = '{"st_miss",  1, 4'hF, 32'h00000100, 32'hCAFEF00D, 2, 32'h0,        1, 4'hF, 32'h00000100, 32'h0,        3};
        vecs[7]  = '{"ld_noalloc",0,4'h0, 32'h00000100, 32'h0,        1, 32'hCAFEF00D, 1, 4'hF, 32'h00000100, 32'hCAFEF00D, 2};
        vecs[8]  = '{"st_hit2",  1, 4'h9, 32'h00000100, 32'h11000022, 1, 32'h0,        1, 4'h9, 32'h00000100, 32'h0,        2};
        vecs[9]  = '{"ld_b2b",   0, 4'h0, 32'h00000100, 32'h0,        1, 32'h0,        0, 4'hF, 32'h0,        32'h11FEF022, 0};
        vecs[10] = '{"ld_lowbits",0,4'h0, 32'h00000103, 32'h0,        1, 32'h0,        0, 4'hF, 32'h0,        32'h11FEF022, 0};

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_be", {28'd0, mem_be}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst cpu_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            access(vecs[i]);
        end

        // Reset during a refill, before mem_ready.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h00020000;
        seen     = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = mem_req;
        end
        check("fill started", {31'd0, seen}, 32'd1);
        rst     = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("rst mid-fill mem_req", {31'd0, mem_req}, 32'd0);
        check("rst mid-fill cpu_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // A line that hit before the reset must now miss.
        v = '{"ld_after_rst", 0, 4'h0, 32'h00000100, 32'h0, 1, 32'h11FEF022, 1, 4'hF,
              32'h00000100, 32'h11FEF022, 2};
        access(v);
        v = '{"ld_after_rst2", 0, 4'h0, 32'h00010000, 32'h0, 2, 32'hDEADABEF, 1, 4'hF,
              32'h00010000, 32'hDEADABEF, 3};
        access(v);

        @(negedge clk);
        cpu_req = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
